// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants: FSM state encoding and oversampling
//               figures, used by both the transmitter and the receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // FSM state encoding (3 bits wide so the receiver can reuse it unchanged)
    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    // Baud ticks per bit period and the last tick index inside one bit
    localparam int         c_OVERSAMPLE = 16;
    localparam logic [3:0] c_TICK_LAST  = 4'd15;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : uart_transmitter
// Description : Serial UART transmit engine. Sends one DATA_BITS-wide word
//               per accepted start pulse, LSB first, with one start bit,
//               optional parity bit and SB_TICK/16 stop bits, timed by an
//               external 16x baud tick. Pulses o_tx_done for one cycle at
//               the end of each frame.
//               Optional feature macro: UART_TX_PARITY_EN (adds a parity
//               bit after the data bits; sense chosen by PARITY_ODD).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_s_tick,
    input  logic                 i_tx_start,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_tx_done,
    output logic                 o_tx
);

    // Stop phase can last two bit periods, which needs a 5-bit tick counter
    localparam int c_SCNT_W = (SB_TICK > c_OVERSAMPLE) ? 5 : 4;

    localparam logic [c_SCNT_W-1:0] c_BIT_LAST  = c_SCNT_W'(c_TICK_LAST);
    localparam logic [c_SCNT_W-1:0] c_STOP_LAST = c_SCNT_W'(SB_TICK - 1);
    localparam logic [2:0]          c_N_LAST    = 3'(DATA_BITS - 1);

    logic [2:0]           r_state, w_state;
    logic [c_SCNT_W-1:0]  r_s_cnt, w_s_cnt;
    logic [2:0]           r_n_cnt, w_n_cnt;
    logic [DATA_BITS-1:0] r_shift, w_shift;
    logic                 r_tx, w_tx;
    logic                 r_tx_done, w_tx_done;

`ifdef UART_TX_PARITY_EN
    // Untouched copy of the word: the shift register is empty by parity time
    logic [DATA_BITS-1:0] r_data_latched, w_data_latched;
    logic                 w_parity;

    assign w_parity = (^r_data_latched) ^ (PARITY_ODD != 0);
`else
    logic                 w_unused_parity_odd;

    assign w_unused_parity_odd = (PARITY_ODD != 0);
`endif

    // State, counters, data and the registered line/done outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= c_IDLE;
            r_s_cnt   <= '0;
            r_n_cnt   <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_data_latched <= '0;
`endif
        end else begin
            r_state   <= w_state;
            r_s_cnt   <= w_s_cnt;
            r_n_cnt   <= w_n_cnt;
            r_shift   <= w_shift;
            r_tx      <= w_tx;
            r_tx_done <= w_tx_done;
`ifdef UART_TX_PARITY_EN
            r_data_latched <= w_data_latched;
`endif
        end
    end

    // Next-state logic; the line level is derived from the state being
    // entered so that o_tx can be a plain register with one cycle latency
    always_comb begin
        w_state   = r_state;
        w_s_cnt   = r_s_cnt;
        w_n_cnt   = r_n_cnt;
        w_shift   = r_shift;
        w_tx_done = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_data_latched = r_data_latched;
`endif
        case (r_state)
            c_IDLE: begin
                // A tick arriving with the start is deliberately not counted
                if (i_tx_start) begin
                    w_shift = i_tx_data;
                    w_s_cnt = '0;
                    w_state = c_START;
`ifdef UART_TX_PARITY_EN
                    w_data_latched = i_tx_data;
`endif
                end
            end
            c_START: begin
                if (i_s_tick) begin
                    if (r_s_cnt == c_BIT_LAST) begin
                        w_s_cnt = '0;
                        w_n_cnt = '0;
                        w_state = c_DATA;
                    end else begin
                        w_s_cnt = r_s_cnt + c_SCNT_W'(1);
                    end
                end
            end
            c_DATA: begin
                if (i_s_tick) begin
                    if (r_s_cnt == c_BIT_LAST) begin
                        w_s_cnt = '0;
                        w_shift = r_shift >> 1;
                        if (r_n_cnt == c_N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            w_state = c_PARITY;
`else
                            w_state = c_STOP;
`endif
                        end else begin
                            w_n_cnt = r_n_cnt + 3'd1;
                        end
                    end else begin
                        w_s_cnt = r_s_cnt + c_SCNT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            c_PARITY: begin
                if (i_s_tick) begin
                    if (r_s_cnt == c_BIT_LAST) begin
                        w_s_cnt = '0;
                        w_state = c_STOP;
                    end else begin
                        w_s_cnt = r_s_cnt + c_SCNT_W'(1);
                    end
                end
            end
`endif
            c_STOP: begin
                if (i_s_tick) begin
                    if (r_s_cnt == c_STOP_LAST) begin
                        w_s_cnt   = '0;
                        w_state   = c_IDLE;
                        w_tx_done = 1'b1;
                    end else begin
                        w_s_cnt = r_s_cnt + c_SCNT_W'(1);
                    end
                end
            end
            default: begin
                w_state = c_IDLE;
            end
        endcase

        case (w_state)
            c_START: w_tx = 1'b0;
            c_DATA:  w_tx = w_shift[0];
`ifdef UART_TX_PARITY_EN
            c_PARITY: w_tx = w_parity;
`endif
            default: w_tx = 1'b1;
        endcase
    end

    assign o_tx      = r_tx;
    assign o_tx_done = r_tx_done;

endmodule : uart_transmitter
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_transmitter
// Description : Self-checking bench for uart_transmitter. A frame-level
//               model (tick count since start -> line level) is compared
//               against the DUT every cycle; directed tests pin the model
//               with hand-computed line samples and done timing.
//               Optional feature macro: UART_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_transmitter;

    localparam int DATA_BITS  = 8;
    localparam int SB_TICK    = 16;
    localparam int PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int P_BITS = 1;
`else
    localparam int P_BITS = 0;
`endif
    localparam int FRAME_TICKS = 16 * (1 + DATA_BITS + P_BITS) + SB_TICK;

    logic                 i_clk      = 1'b0;
    logic                 i_reset    = 1'b1;
    logic                 i_s_tick   = 1'b0;
    logic                 i_tx_start = 1'b0;
    logic [DATA_BITS-1:0] i_tx_data  = '0;
    logic                 o_tx_done;
    logic                 o_tx;

    uart_transmitter #(
        .DATA_BITS (DATA_BITS),
        .SB_TICK   (SB_TICK),
        .PARITY_ODD(PARITY_ODD)
    ) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_s_tick  (i_s_tick),
        .i_tx_start(i_tx_start),
        .i_tx_data (i_tx_data),
        .o_tx_done (o_tx_done),
        .o_tx      (o_tx)
    );

`ifdef UART_TX_PARITY_EN
    logic o_tx_done_odd;
    logic o_tx_odd;
    logic smp_odd [0:2047];

    uart_transmitter #(
        .DATA_BITS (DATA_BITS),
        .SB_TICK   (SB_TICK),
        .PARITY_ODD(1)
    ) dut_odd (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_s_tick  (i_s_tick),
        .i_tx_start(i_tx_start),
        .i_tx_data (i_tx_data),
        .o_tx_done (o_tx_done_odd),
        .o_tx      (o_tx_odd)
    );
`endif

    always #5 i_clk = ~i_clk;

    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;
    int   tick_div = 1;
    int   tphase   = 0;
    logic smp [0:2047];
    int   dones;
    int   first_done;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    function automatic logic line_at(input bit busy, input int t, input logic [DATA_BITS-1:0] d);
        int idx;
        if (!busy) return 1'b1;
        idx = t / 16;
        if (idx == 0) return 1'b0;
        if (idx <= DATA_BITS) return d[idx-1];
        if (P_BITS == 1 && idx == DATA_BITS + 1) return (^d) ^ (PARITY_ODD != 0);
        return 1'b1;
    endfunction

    bit                   m_busy;
    int                   m_t;
    logic [DATA_BITS-1:0] m_byte;
    logic                 m_tx;
    logic                 m_done;

    always @(posedge i_clk) begin : model
        int                   t;
        bit                   busy;
        bit                   dn;
        logic [DATA_BITS-1:0] d;
        if (i_reset) begin
            m_busy <= 1'b0;
            m_t    <= 0;
            m_byte <= '0;
            m_tx   <= 1'b1;
            m_done <= 1'b0;
        end else begin
            t    = m_t;
            busy = m_busy;
            d    = m_byte;
            dn   = 1'b0;
            if (busy) begin
                if (i_s_tick) begin
                    t = t + 1;
                    if (t == FRAME_TICKS) begin
                        busy = 1'b0;
                        dn   = 1'b1;
                    end
                end
            end else if (i_tx_start) begin
                busy = 1'b1;
                t    = 0;
                d    = i_tx_data;
            end
            m_t    <= t;
            m_busy <= busy;
            m_byte <= d;
            m_done <= dn;
            m_tx   <= line_at(busy, t, d);
        end
    end

    // Every-cycle comparison against the model
    always @(negedge i_clk) begin
        if (chk_en) begin
            chk("model_tx", {31'd0, o_tx}, {31'd0, m_tx});
            chk("model_done", {31'd0, o_tx_done}, {31'd0, m_done});
        end
    end

    // ---------------- stimulus helpers ----------------
    // Drive inputs for the coming edge, then wait until just after it
    task automatic cycle(input logic start, input logic [DATA_BITS-1:0] d);
        i_tx_start = start;
        i_tx_data  = d;
        if (tick_div == 0) begin
            i_s_tick = 1'b0;
        end else begin
            i_s_tick = (tphase == 0);
            tphase   = (tphase + 1) % tick_div;
        end
        @(negedge i_clk);
    endtask

    // Start a frame on edge 0; smp[n] is the line just after edge n
    task automatic send(input logic [DATA_BITS-1:0] d, input int ncyc, input int inj_at,
                        input logic [DATA_BITS-1:0] inj_d, input int rst_at);
        dones      = 0;
        first_done = -1;
        tphase     = 0;
        for (int n = 0; n < ncyc; n++) begin
            i_reset = (n == rst_at);
            cycle((n == 0) || (n == inj_at), (n == 0) ? d : inj_d);
            smp[n] = o_tx;
`ifdef UART_TX_PARITY_EN
            smp_odd[n] = o_tx_odd;
`endif
            if (o_tx_done) begin
                dones++;
                if (first_done < 0) first_done = n;
            end
        end
        i_reset = 1'b0;
    endtask

    function automatic logic [7:0] decode(input int fs, input int stride);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = smp[fs + stride * (k + 1) + stride / 2];
        return b;
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        logic [9:0]  pat;
        logic [31:0] word;
        int          bidx;
        logic        nxt;
        int          unstable;

        @(negedge i_clk);
        i_reset = 1'b1;
        repeat (3) cycle(1'b0, '0);
        chk_en = 1'b1;
        chk("reset_tx", {31'd0, o_tx}, 32'd1);
        chk("reset_done", {31'd0, o_tx_done}, 32'd0);
        i_reset = 1'b0;
        repeat (3) cycle(1'b0, '0);

        // 0xA5, tick every cycle: start, LSB-first data, stop/parity
        tick_div = 1;
        send(8'hA5, 220, -1, '0, -1);
        pat = 10'b1101001010;
        for (int k = 0; k < 9; k++) chk("a5_bit", {31'd0, smp[16 * k + 8]}, {31'd0, pat[k]});
        chk("a5_bit9", {31'd0, smp[16 * 9 + 8]}, (P_BITS == 1) ? 32'd0 : 32'd1);
        chk("a5_done_at", first_done, FRAME_TICKS);
        chk("a5_done_cnt", dones, 32'd1);
        chk("a5_decode", {24'd0, decode(0, 16)}, 32'h0000_00A5);

        // 0x3C with a second start (0xFF) mid-frame, which must be ignored
        send(8'h3C, 220, 40, 8'hFF, -1);
        chk("3c_done_cnt", dones, 32'd1);
        chk("3c_done_at", first_done, FRAME_TICKS);
        chk("3c_decode", {24'd0, decode(0, 16)}, 32'h0000_003C);

        // 0x01 with a tick every 4th cycle
        tick_div = 4;
        send(8'h01, 4 * FRAME_TICKS + 20, -1, '0, -1);
        chk("t4_done_at", first_done, 4 * FRAME_TICKS);
        chk("t4_decode", {24'd0, decode(0, 64)}, 32'h0000_0001);
        chk("t4_start_low", {31'd0, smp[63]}, 32'd0);
        chk("t4_bit0_high", {31'd0, smp[64]}, 32'd1);
        unstable = 0;
        for (int k = 0; k < 10; k++)
            for (int j = 1; j < 64; j++)
                if (smp[64 * k + j] !== smp[64 * k]) unstable++;
        chk("t4_stable", unstable, 32'd0);
        tick_div = 1;

        // 0x55 aborted by reset at edge 70, then a clean 0x0F frame
        send(8'h55, 220, -1, '0, 70);
        chk("rst_before", {31'd0, smp[69]}, 32'd0);
        chk("rst_tx_high", {31'd0, smp[70]}, 32'd1);
        chk("rst_idle", {31'd0, smp[120]}, 32'd1);
        chk("rst_no_done", dones, 32'd0);
        send(8'h0F, 220, -1, '0, -1);
        chk("0f_done_at", first_done, FRAME_TICKS);
        chk("0f_decode", {24'd0, decode(0, 16)}, 32'h0000_000F);

        // Upstream buffer emulation: word 0x11223344 sent LSB byte first,
        // next byte started on the cycle of each done pulse
        word  = 32'h1122_3344;
        bidx  = 0;
        nxt   = 1'b1;
        dones = 0;
        for (int n = 0; n < 4 * (FRAME_TICKS + 1) + 40; n++) begin
            cycle(nxt, (bidx < 4) ? word[8 * bidx +: 8] : 8'h00);
            nxt    = 1'b0;
            smp[n] = o_tx;
            if (o_tx_done) begin
                dones++;
                bidx++;
                nxt = (bidx < 4);
            end
        end
        chk("chain_dones", dones, 32'd4);
        chk("chain_b0", {24'd0, decode(0, 16)}, 32'h0000_0044);
        chk("chain_b1", {24'd0, decode(FRAME_TICKS + 1, 16)}, 32'h0000_0033);
        chk("chain_b2", {24'd0, decode(2 * (FRAME_TICKS + 1), 16)}, 32'h0000_0022);
        chk("chain_b3", {24'd0, decode(3 * (FRAME_TICKS + 1), 16)}, 32'h0000_0011);
        chk("chain_gap_idle", {31'd0, smp[FRAME_TICKS]}, 32'd1);
        chk("chain_gap_start", {31'd0, smp[FRAME_TICKS + 1]}, 32'd0);

`ifdef UART_TX_PARITY_EN
        // Odd parity of 0x07 (three ones) is 0
        send(8'h07, 220, -1, '0, -1);
        chk("odd_par_07", {31'd0, smp_odd[16 * 9 + 8]}, 32'd0);
        chk("even_par_07", {31'd0, smp[16 * 9 + 8]}, 32'd1);
        chk("par_len", first_done, 32'd176);
`endif

        repeat (4) cycle(1'b0, '0);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_transmitter
`default_nettype wire

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serial UART transmit engine; consumes one byte per start pulse from the FIFO-to-UART byte buffer and drives the TX line. Frame: 8N1 by default, LSB first, 16x oversampled timing.
- Bit timing comes from an external baud tick (one-cycle pulse at 16x baud).
- Returns a one-cycle done pulse per frame. The upstream buffer advances to the next byte of its 32-bit word on that pulse.

Parameters:
DATA_BITS, 8, data bits per frame (1..8)
SB_TICK, 16, baud ticks spent in stop state (16 = 1 stop bit, 32 = 2)
PARITY_ODD, 0, parity sense when UART_TX_PARITY_EN is defined (0 = even, 1 = odd); ignored otherwise

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_s_tick  in  1  16x baud tick, one i_clk cycle wide
i_tx_start  in  1  start request, one-cycle pulse
i_tx_data  in  DATA_BITS  byte to send, sampled when start is accepted
o_tx_done  out  1  one-cycle pulse at frame end
o_tx  out  1  serial line, idle high, registered

Behaviour:
- Single clock i_clk; reset synchronous, active-high on i_reset.
- Reset values: state=IDLE, o_tx=1, o_tx_done=0, tick counter=0, bit counter=0, shift reg=0.
- Reset mid-frame: o_tx=1 after the next edge; no done pulse.
- States: IDLE, START, DATA, [PARITY], STOP.
- Tick counter s_cnt is 4 bits and counts i_s_tick only. Bit counter n_cnt is 3 bits.

IDLE:
- o_tx=1.
- If i_tx_start=1: latch i_tx_data into shift reg, s_cnt<=0, go to START.
- o_tx is low from the edge that accepts start (latency 1 cycle).

START:
- o_tx=0.
- On tick with s_cnt==15: s_cnt<=0, n_cnt<=0, go to DATA. Otherwise, on tick, s_cnt++.

DATA:
- o_tx = shift reg bit 0.
- On tick with s_cnt==15: shift right, s_cnt<=0.
- If n_cnt==DATA_BITS-1, go to PARITY (if the macro is defined) or STOP; else n_cnt++.

STOP:
- o_tx=1.
- On tick with s_cnt==SB_TICK-1: go to IDLE and assert o_tx_done for exactly that one cycle (registered).
- s_cnt is 5 bits when SB_TICK>16.

General rules:
- No tick means the FSM holds; tick gaps of any length are legal.
- i_tx_start outside IDLE is ignored. No queuing, data not resampled.
- Start in the same cycle as the done pulse: the FSM is already IDLE, so start is accepted. This gives back-to-back frames with one idle-high cycle minimum.
- i_s_tick coincident with accepted start is not counted (s_cnt cleared).
- o_tx_done is never asserted outside the STOP→IDLE transition.
- Frame length: 16*(1+DATA_BITS+P) + SB_TICK ticks, where P=1 with parity and P=0 without.

Optional Feature:
UART_TX_PARITY_EN
- Defined: the PARITY state follows DATA. o_tx = (^data_latched) XOR PARITY_ODD, held 16 ticks, then STOP.
- Parity is computed from a copy of the byte captured at start, not from the shifted register.
- Undefined: no PARITY state or logic; DATA goes directly to STOP; PARITY_ODD is unused.

Decomposition:
- Package uart_pkg: state encoding localparams (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4), OVERSAMPLE=16, TICK_LAST=15.
- These are shared with the receiver.
- No sub-module. The baud tick generator stays a separate, existing block instantiated at the top level.

Test Plan:
- Tick every cycle, start with 0xA5 → o_tx bits 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each held 16 cycles. o_tx_done is high exactly at cycle 160 after start.
- Start 0x3C then second start with 0xFF at cycle 40 → second start ignored; line carries only 0x3C; one done pulse.
- Tick every 4th cycle, byte 0x01 → each bit lasts 64 cycles; done at cycle 640; o_tx stable between ticks.
- Reset asserted at cycle 70 of a 0x55 frame → o_tx=1, state IDLE next edge, no done. A new start with 0x0F afterwards produces a correct frame.
- Chained with the upstream byte buffer and FIFO word 0x11223344 → bytes 0x44, 0x33, 0x22, 0x11 in order, exactly four done pulses, one idle cycle minimum between frames.
- With UART_TX_PARITY_EN and PARITY_ODD=0, byte 0xA5 → parity bit 0, frame length 176 ticks. With PARITY_ODD=1, byte 0x07 → parity bit 0.
